// File: rtl/rr_arbiter8_enc.sv
// Round-robin arbiter for 8 requesters with registered one-hot/encoded grant.
// Enforces release on done, dropped request or hold timeout.
module rr_arbiter8_enc #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic [2:0] win;
    logic       found;
    logic       hold_max;
    logic       rel;

    // Scan downward so the nearest set bit at or after ptr wins last.
    always_comb begin
        win   = ptr_q;
        found = |req;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                win = ptr_q + 3'(i);
            end
        end
    end

    assign hold_max = (cnt_q == CNT_W'(MAX_HOLD));
    assign rel      = done | ~req[idx_q] | hold_max;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    gnt_d   = 8'd1 << win;
                    idx_d   = win;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_GRANT: begin
                if (rel) begin
                    state_d = S_IDLE;
                    gnt_d   = 8'h00;
                    ptr_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    // Only the hold limit can release with done low and req held.
                    tmo_d   = ~done & req[idx_q];
                end else if (!hold_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            gnt_q   <= 8'h00;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = tmo_q;

endmodule
